// File: rtl/mod_writeback.sv
// Writeback stage: commits up to two results per instruction into the register file,
// keeps the pending-write scoreboard and retires instructions. `WB_BYPASS_EN adds write-to-read forwarding.
module mod_writeback #(
    parameter  int NREGS = 16,
    parameter  int XLEN  = 64,
    localparam int IW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [63:0]     wb_pc,
    input  logic [XLEN-1:0] wb_result,
    input  logic [XLEN-1:0] wb_ext_result,
    input  logic [IW-1:0]   wb_dst,
    input  logic [IW-1:0]   wb_dst2,
    input  logic            wb_wen,
    input  logic            wb_wen2,
    input  logic            wb_sim_end,
    input  logic            sb_set,
    input  logic [IW-1:0]   sb_set_idx,
    input  logic [IW-1:0]   ra_idx,
    input  logic [IW-1:0]   rb_idx,
    output logic [XLEN-1:0] ra_data,
    output logic [XLEN-1:0] rb_data,
    output logic [NREGS-1:0] score_board,
    output logic [63:0]     retired_count,
    output logic [63:0]     last_pc,
    output logic            sim_done,
    output logic            sb_error,
    output logic [1:0]      dbg_state
);

    // Handshake: an entry moves when wb_valid && wb_ready at a rising edge; wb_ready
    // depends on state only, and an entry offered while wb_ready=0 stays with upstream.
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_SECOND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [XLEN-1:0] r_regs [NREGS];
    logic [1:0]      r_cnt  [NREGS];
    logic [1:0]      w_cnt_next [NREGS];
    logic            w_sb_err;

    logic [XLEN-1:0] r_ext;
    logic [IW-1:0]   r_dst2;
    logic [63:0]     r_pc;
    logic            r_end;

    logic [63:0]     r_retired;
    logic [63:0]     r_last_pc;
    logic            r_sb_error;

    logic            w_we;
    logic [IW-1:0]   w_widx;
    logic [XLEN-1:0] w_wdata;
    logic            w_latch;
    logic            w_retire;
    logic [63:0]     w_retire_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        wb_ready     = 1'b0;
        w_we         = 1'b0;
        w_widx       = '0;
        w_wdata      = '0;
        w_latch      = 1'b0;
        w_retire     = 1'b0;
        w_retire_pc  = '0;
        case (r_state)
            S_RUN: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    if (wb_wen && wb_wen2) begin
                        w_we         = 1'b1;
                        w_widx       = wb_dst;
                        w_wdata      = wb_result;
                        w_latch      = 1'b1;
                        w_state_next = S_SECOND;
                    end else begin
                        if (wb_wen) begin
                            w_we    = 1'b1;
                            w_widx  = wb_dst;
                            w_wdata = wb_result;
                        end else if (wb_wen2) begin
                            w_we    = 1'b1;
                            w_widx  = wb_dst2;
                            w_wdata = wb_ext_result;
                        end
                        w_retire    = 1'b1;
                        w_retire_pc = wb_pc;
                        if (wb_sim_end) begin
                            w_state_next = S_DONE;
                        end
                    end
                end
            end
            S_SECOND: begin
                w_we         = 1'b1;
                w_widx       = r_dst2;
                w_wdata      = r_ext;
                w_retire     = 1'b1;
                w_retire_pc  = r_pc;
                w_state_next = r_end ? S_DONE : S_RUN;
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext  <= '0;
            r_dst2 <= '0;
            r_pc   <= '0;
            r_end  <= 1'b0;
        end else if (w_latch) begin
            r_ext  <= wb_ext_result;
            r_dst2 <= wb_dst2;
            r_pc   <= wb_pc;
            r_end  <= wb_sim_end;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_widx] <= w_wdata;
        end
    end

    // A claim and a commit to the same register in one cycle cancel out.
    always_comb begin
        w_sb_err = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (sb_set && (sb_set_idx == IW'(i)) && !(w_we && (w_widx == IW'(i)))) begin
                if (r_cnt[i] == 2'd3) begin
                    w_sb_err = 1'b1;
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 2'd1;
                end
            end else if (w_we && (w_widx == IW'(i)) && !(sb_set && (sb_set_idx == IW'(i)))) begin
                if (r_cnt[i] == 2'd0) begin
                    w_sb_err = 1'b1;
                end else begin
                    w_cnt_next[i] = r_cnt[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= 2'd0;
            end
            r_sb_error <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            if (w_sb_err) begin
                r_sb_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
            r_last_pc <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 64'd1;
            r_last_pc <= w_retire_pc;
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            score_board[i] = (r_cnt[i] != 2'd0);
        end
    end

`ifdef WB_BYPASS_EN
    assign ra_data = (w_we && (w_widx == ra_idx)) ? w_wdata : r_regs[ra_idx];
    assign rb_data = (w_we && (w_widx == rb_idx)) ? w_wdata : r_regs[rb_idx];
`else
    assign ra_data = r_regs[ra_idx];
    assign rb_data = r_regs[rb_idx];
`endif

    assign retired_count = r_retired;
    assign last_pc       = r_last_pc;
    assign sim_done      = (r_state == S_DONE);
    assign sb_error      = r_sb_error;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_mod_writeback.sv
// Bench for mod_writeback: directed scenarios plus random traffic, all checked against
// a behavioural model of registers, pending counters and a queue of deferred second writes.
module tb_mod_writeback;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_pc;
    logic [63:0] wb_result;
    logic [63:0] wb_ext_result;
    logic [3:0]  wb_dst;
    logic [3:0]  wb_dst2;
    logic        wb_wen;
    logic        wb_wen2;
    logic        wb_sim_end;
    logic        sb_set;
    logic [3:0]  sb_set_idx;
    logic [3:0]  ra_idx;
    logic [3:0]  rb_idx;
    logic [63:0] ra_data;
    logic [63:0] rb_data;
    logic [15:0] score_board;
    logic [63:0] retired_count;
    logic [63:0] last_pc;
    logic        sim_done;
    logic        sb_error;
    logic [1:0]  dbg_state;

    mod_writeback #(.NREGS(16), .XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_pc(wb_pc), .wb_result(wb_result), .wb_ext_result(wb_ext_result),
        .wb_dst(wb_dst), .wb_dst2(wb_dst2), .wb_wen(wb_wen), .wb_wen2(wb_wen2),
        .wb_sim_end(wb_sim_end), .sb_set(sb_set), .sb_set_idx(sb_set_idx),
        .ra_idx(ra_idx), .rb_idx(rb_idx), .ra_data(ra_data), .rb_data(rb_data),
        .score_board(score_board), .retired_count(retired_count), .last_pc(last_pc),
        .sim_done(sim_done), .sb_error(sb_error), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    typedef struct {
        int          idx;
        logic [63:0] data;
        logic [63:0] pc;
        bit          fin;
    } pend_t;

    logic [63:0] m_regs [16];
    int          m_cnt  [16];
    pend_t       m_pend [$];
    logic [63:0] m_retired;
    logic [63:0] m_last_pc;
    bit          m_done;
    bit          m_err;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
        m_pend.delete();
        m_retired = '0;
        m_last_pc = '0;
        m_done    = 1'b0;
        m_err     = 1'b0;
    endfunction

    // The register write that happens at the coming edge, if any.
    function automatic void cur_write(output bit we, output int idx, output logic [63:0] data);
        we = 1'b0; idx = 0; data = '0;
        if (reset) return;
        if (m_pend.size() > 0) begin
            we = 1'b1; idx = m_pend[0].idx; data = m_pend[0].data;
        end else if (!m_done && wb_valid) begin
            if (wb_wen) begin
                we = 1'b1; idx = int'(wb_dst); data = wb_result;
            end else if (wb_wen2) begin
                we = 1'b1; idx = int'(wb_dst2); data = wb_ext_result;
            end
        end
    endfunction

    function automatic logic [63:0] exp_read(input logic [3:0] ridx);
        bit we; int idx; logic [63:0] data;
        cur_write(we, idx, data);
`ifdef WB_BYPASS_EN
        if (we && idx == int'(ridx)) return data;
`endif
        return m_regs[ridx];
    endfunction

    function automatic void model_edge();
        bit we; int idx; logic [63:0] data; pend_t e;
        cur_write(we, idx, data);
        if (reset) begin
            model_clear();
            return;
        end
        for (int i = 0; i < 16; i++) begin
            int delta;
            delta = ((sb_set && int'(sb_set_idx) == i) ? 1 : 0) - ((we && idx == i) ? 1 : 0);
            if (delta > 0) begin
                if (m_cnt[i] == 3) m_err = 1'b1; else m_cnt[i] = m_cnt[i] + 1;
            end else if (delta < 0) begin
                if (m_cnt[i] == 0) m_err = 1'b1; else m_cnt[i] = m_cnt[i] - 1;
            end
        end
        if (we) m_regs[idx] = data;
        if (m_pend.size() > 0) begin
            e = m_pend.pop_front();
            m_retired = m_retired + 1;
            m_last_pc = e.pc;
            if (e.fin) m_done = 1'b1;
        end else if (!m_done && wb_valid) begin
            if (wb_wen && wb_wen2) begin
                e.idx = int'(wb_dst2); e.data = wb_ext_result; e.pc = wb_pc; e.fin = wb_sim_end;
                m_pend.push_back(e);
            end else begin
                m_retired = m_retired + 1;
                m_last_pc = wb_pc;
                if (wb_sim_end) m_done = 1'b1;
            end
        end
    endfunction

    function automatic logic [15:0] exp_sb();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = (m_cnt[i] != 0);
        return v;
    endfunction

    // driver tasks: inputs change just after a falling edge
    task automatic set_idle();
        wb_valid = 1'b0; wb_wen = 1'b0; wb_wen2 = 1'b0; wb_sim_end = 1'b0;
        sb_set = 1'b0; reset = 1'b0;
    endtask

    task automatic step();
        #1;
        if (!reset) begin
            chk("wb_ready", {63'd0, wb_ready}, {63'd0, !m_done && m_pend.size() == 0});
            chk("ra_data", ra_data, exp_read(ra_idx));
            chk("rb_data", rb_data, exp_read(rb_idx));
        end
        @(posedge clk);
        model_edge();
        #1;
        chk("score_board", {48'd0, score_board}, {48'd0, exp_sb()});
        chk("retired_count", retired_count, m_retired);
        chk("last_pc", last_pc, m_last_pc);
        chk("sim_done", {63'd0, sim_done}, {63'd0, m_done});
        chk("sb_error", {63'd0, sb_error}, {63'd0, m_err});
        @(negedge clk);
    endtask

    task automatic drive_wb(input logic wen, input logic wen2, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [63:0] r1, input logic [63:0] r2,
                            input logic [63:0] pc, input logic fin);
        wb_valid = 1'b1; wb_wen = wen; wb_wen2 = wen2; wb_dst = d1; wb_dst2 = d2;
        wb_result = r1; wb_ext_result = r2; wb_pc = pc; wb_sim_end = fin;
    endtask

    task automatic claim(input logic [3:0] r);
        set_idle(); sb_set = 1'b1; sb_set_idx = r; step(); set_idle();
    endtask

    initial begin
        model_clear();
        set_idle();
        reset = 1'b1;
        wb_pc = '0; wb_result = '0; wb_ext_result = '0; wb_dst = '0; wb_dst2 = '0;
        sb_set_idx = '0; ra_idx = '0; rb_idx = '0;
        step(); step();
        set_idle();

        // all registers read zero after reset
        for (int i = 0; i < 16; i++) begin
            ra_idx = 4'(i); rb_idx = 4'(15 - i);
            #1 chk("reset_reg", ra_data, 64'd0);
            step();
        end
        chk("reset_ready", {63'd0, wb_ready}, 64'd1);

        // single write clears a claim
        claim(4'd3);
        chk("sb3_set", {63'd0, score_board[3]}, 64'd1);
        drive_wb(1'b1, 1'b0, 4'd3, 4'd0, 64'hDEAD, 64'h0, 64'h100, 1'b0);
        step(); set_idle();
        chk("sb3_clear", {63'd0, score_board[3]}, 64'd0);
        chk("retire_one", retired_count, 64'd1);
        ra_idx = 4'd3;
        #1 chk("r3_value", ra_data, 64'hDEAD);
        step();

        // dual write: ready drops for one cycle, one retirement
        claim(4'd1); claim(4'd2);
        drive_wb(1'b1, 1'b1, 4'd1, 4'd2, 64'h10, 64'h20, 64'h104, 1'b0);
        step(); set_idle();
        chk("dual_ready_low", {63'd0, wb_ready}, 64'd0);
        ra_idx = 4'd1; rb_idx = 4'd2;
        #1 chk("dual_r1", ra_data, 64'h10);
        step();
        chk("dual_retired", retired_count, 64'd2);
        #1 chk("dual_r2", rb_data, 64'h20);
        step();

        // scoreboard saturation
        for (int k = 0; k < 4; k++) claim(4'd5);
        chk("sat_error", {63'd0, sb_error}, 64'd1);

        // same-cycle read of a register being written
        ra_idx = 4'd7;
        drive_wb(1'b1, 1'b0, 4'd7, 4'd0, 64'h55, 64'h0, 64'h108, 1'b0);
`ifdef WB_BYPASS_EN
        #1 chk("bypass_r7", ra_data, 64'h55);
`else
        #1 chk("bypass_r7", ra_data, 64'h0);
`endif
        step(); set_idle();

        // sim_end retirement freezes the stage
        drive_wb(1'b0, 1'b0, 4'd0, 4'd0, 64'h0, 64'h0, 64'h10C, 1'b1);
        step(); set_idle();
        chk("done_flag", {63'd0, sim_done}, 64'd1);
        chk("done_ready", {63'd0, wb_ready}, 64'd0);
        ra_idx = 4'd4;
        drive_wb(1'b1, 1'b0, 4'd4, 4'd0, 64'hBEEF, 64'h0, 64'h110, 1'b0);
        step(); step(); set_idle();
        #1 chk("done_no_write", ra_data, 64'd0);
        chk("done_no_retire", retired_count, 64'd4);

        // reset in the middle of a dual write drops the second half
        reset = 1'b1; step(); set_idle();
        drive_wb(1'b1, 1'b1, 4'd8, 4'd9, 64'h88, 64'h99, 64'h200, 1'b0);
        step(); set_idle();
        reset = 1'b1; step(); set_idle();
        ra_idx = 4'd8; rb_idx = 4'd9;
        #1 chk("mid_reset_r8", ra_data, 64'd0);
        chk("mid_reset_r9", rb_data, 64'd0);
        chk("mid_reset_ready", {63'd0, wb_ready}, 64'd1);
        step();

        // random traffic
        for (int k = 0; k < 800; k++) begin
            reset      = ($urandom_range(0, 79) == 0);
            wb_valid   = ($urandom_range(0, 3) != 0);
            wb_wen     = $urandom_range(0, 1);
            wb_wen2    = $urandom_range(0, 1);
            wb_dst     = 4'($urandom_range(0, 15));
            wb_dst2    = 4'($urandom_range(0, 15));
            wb_result  = {$urandom, $urandom};
            wb_ext_result = {$urandom, $urandom};
            wb_pc      = {32'd0, $urandom};
            wb_sim_end = ($urandom_range(0, 49) == 0);
            sb_set     = ($urandom_range(0, 2) == 0);
            sb_set_idx = 4'($urandom_range(0, 15));
            ra_idx     = 4'($urandom_range(0, 15));
            rb_idx     = 4'($urandom_range(0, 15));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
